// File: rtl/zero_cross_period_meter.sv
// Rising zero-crossing period meter with hysteresis, block averaging and
// signal-loss detection (low amplitude or missing crossings).
module zero_cross_period_meter #(
  parameter int N              = 8,
  parameter int HYST           = 4,
  parameter int MIN_VPP        = 16,
  parameter int AVG_LOG2       = 2,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [N-1:0]     signal_in,
  input  logic [N-1:0]     vpp_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             signal_lost
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 < 1) ? 1 : AVG_LOG2;

  localparam logic signed [N:0]  HYST_P    = (N+1)'(HYST);
  localparam logic signed [N:0]  HYST_N    = -HYST_P;
  localparam logic [N-1:0]       MIN_VPP_L = N'(MIN_VPP);
  localparam logic [CNT_W-1:0]   TMO       = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_e;

  state_e             state_q, state_d;
  logic               pol_q, pol_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               valid_q, valid_d;
  logic               lost_q, lost_d;

  logic signed [N:0]  sig_x;
  logic               ge_pos;
  logic               le_neg;
  logic               rise;
  logic               vpp_ok;
  logic               cnt_at_tmo;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ACC_W-1:0]   sum;
  logic               abort;

  // Comparator and shared datapath terms
  always_comb begin
    sig_x      = {signal_in[N-1], signal_in};
    ge_pos     = (sig_x >= HYST_P);
    le_neg     = (sig_x <= HYST_N);
    rise       = sample_en & ~pol_q & ge_pos;
    vpp_ok     = (vpp_in >= MIN_VPP_L);
    cnt_at_tmo = (cnt_q == TMO);
    cnt_inc    = cnt_at_tmo ? cnt_q : (cnt_q + CNT_ONE);
    sum        = acc_q + ACC_W'(cnt_q);
  end

  // Next-state logic: hysteresis polarity, period counter, averaging FSM
  always_comb begin
    state_d  = state_q;
    pol_d    = pol_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    period_d = period_q;
    valid_d  = 1'b0;
    lost_d   = lost_q;
    abort    = 1'b0;

    if (sample_en) begin
      if (ge_pos) begin
        pol_d = 1'b1;
      end else if (le_neg) begin
        pol_d = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        acc_d = '0;
        idx_d = '0;
        if (vpp_ok) begin
          state_d = ARM;
        end
      end
      ARM: begin
        cnt_d = cnt_inc;
        // amplitude loss outranks a crossing, which outranks a timeout
        if (!vpp_ok) begin
          abort = 1'b1;
        end else if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = MEASURE;
        end else if (cnt_at_tmo) begin
          abort = 1'b1;
        end
      end
      MEASURE: begin
        cnt_d = cnt_inc;
        if (!vpp_ok) begin
          abort = 1'b1;
        end else if (rise) begin
          cnt_d = CNT_ONE;
          if (idx_q == IDX_LAST) begin
            period_d = CNT_W'(sum >> AVG_LOG2);
            valid_d  = 1'b1;
            lost_d   = 1'b0;
            acc_d    = '0;
            idx_d    = '0;
          end else begin
            acc_d = sum;
            idx_d = idx_q + IDX_ONE;
          end
        end else if (cnt_at_tmo) begin
          abort = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
      lost_d  = 1'b1;
      cnt_d   = '0;
      acc_d   = '0;
      idx_d   = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pol_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pol_q    <= pol_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign signal_lost  = lost_q;

endmodule

// File: tb/tb_zero_cross_period_meter.sv
// Scoreboard bench for zero_cross_period_meter: stimulus pushes the expected
// averaged period per block; a monitor pops on every period_valid pulse.
module tb_zero_cross_period_meter;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sample_en = 1'b1;
  logic signed [7:0] sig = '0;
  logic [7:0]        vpp = '0;
  logic [23:0]       period_out;
  logic              period_valid;
  logic              signal_lost;

  int total = 0;
  int bad   = 0;
  int sb[$];
  int last_exp = 0;
  logic prev_valid = 1'b0;

  zero_cross_period_meter #(
    .N(8),
    .HYST(4),
    .MIN_VPP(16),
    .AVG_LOG2(2),
    .CNT_W(24),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_en(sample_en),
    .signal_in(sig),
    .vpp_in(vpp),
    .period_out(period_out),
    .period_valid(period_valid),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every period_valid pulse must match the oldest expected block
  always @(posedge clk) begin
    #1;
    if (!rst && period_valid) begin
      chk("valid_pulse_width", int'(prev_valid), 0);
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        chk("period_out", int'(period_out), sb.pop_front());
      end
    end
    prev_valid = period_valid;
  end

  task automatic idle_cycles(input int n, input logic signed [7:0] v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sig = v;
    end
  endtask

  task automatic wave(input int p);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      sig = (i < p / 2) ? 8'sd20 : -8'sd20;
    end
  endtask

  task automatic run_block(input int a, input int b, input int c, input int d);
    int e;
    e = (a + b + c + d) >> 2;
    sb.push_back(e);
    last_exp = e;
    wave(a);
    wave(b);
    wave(c);
    wave(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_period_out", int'(period_out), 0);
    chk("rst_valid", int'(period_valid), 0);
    chk("rst_lost", int'(signal_lost), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_pending", sb.size(), 0);
  endtask

  initial begin
    // 1: reset with random inputs, then stay below MIN_VPP
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sig = $signed(8'($urandom));
      vpp = 8'($urandom);
      sample_en = 1'($urandom);
      #1;
      chk("in_rst_outputs", int'({period_out, period_valid, signal_lost}), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    sample_en = 1'b1;
    vpp = 8'd10;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      sig = (i % 2 == 0) ? 8'sd40 : -8'sd40;
    end
    chk("post_rst_period", int'(period_out), 0);
    chk("post_rst_lost", int'(signal_lost), 0);

    // 4: amplitude below hysteresis -> timeout in ARM
    do_reset();
    vpp = 8'd40;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      sig = (i % 2 == 0) ? 8'sd3 : -8'sd3;
    end
    chk("small_sig_lost_early", int'(signal_lost), 0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      sig = (i % 2 == 0) ? 8'sd3 : -8'sd3;
    end
    chk("small_sig_lost_late", int'(signal_lost), 1);

    // 2/3: steady square wave and truncating averages
    do_reset();
    vpp = 8'd40;
    idle_cycles(5, -8'sd20);
    run_block(100, 100, 100, 100);
    run_block(100, 100, 100, 100);
    run_block(98, 102, 99, 101);
    run_block(100, 100, 100, 101);
    run_block(103, 103, 103, 104);
    run_block(50, 60, 70, 81);
    wave(100);
    wave(100);
    drain();
    chk("lost_after_blocks", int'(signal_lost), 0);

    // 5: vpp drop mid-block
    @(negedge clk);
    sig = -8'sd20;
    vpp = 8'd10;
    @(posedge clk);
    #1;
    chk("vpp_drop_lost", int'(signal_lost), 1);
    chk("vpp_drop_period_hold", int'(period_out), last_exp);
    @(negedge clk);
    vpp = 8'd40;
    idle_cycles(5, -8'sd20);
    chk("lost_before_rearm_block", int'(signal_lost), 1);
    run_block(120, 120, 120, 120);
    wave(10);
    drain();
    chk("lost_cleared_after_valid", int'(signal_lost), 0);
    chk("period_after_recover", int'(period_out), 120);

    // 6: rise on the exact timeout cycle wins; then a MEASURE timeout
    do_reset();
    vpp = 8'd40;
    idle_cycles(5, -8'sd20);
    run_block(1000, 1000, 1000, 1000);
    wave(10);
    drain();
    chk("tmo_edge_no_lost", int'(signal_lost), 0);
    wave(1100);
    chk("measure_timeout_lost", int'(signal_lost), 1);
    chk("measure_timeout_hold", int'(period_out), 1000);

    // 6: reset mid-block discards partial average, then clean restart
    idle_cycles(5, -8'sd20);
    wave(100);
    wave(100);
    do_reset();
    vpp = 8'd40;
    idle_cycles(5, -8'sd20);
    run_block(90, 90, 90, 90);
    wave(10);
    drain();
    chk("restart_period", int'(period_out), 90);
    chk("restart_lost", int'(signal_lost), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
